// File: rtl/ervp_dma_seq_pkg.sv
// Shared types and constants for the DMA descriptor sequencer.
// Holds the FSM state encoding, status bit positions and 4 KB page helper.
package ervp_dma_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_RD_CMD    = 3'd3,
    S_WR_CMD    = 3'd4,
    S_WAIT_RESP = 3'd5
  } seq_state_e;

  localparam int STATUS_DONE  = 0;
  localparam int STATUS_ERROR = 1;
  localparam int STATUS_BUSY  = 2;

  localparam int BEAT_BYTES = 4;
  localparam int BOUNDARY   = 4096;

  // Beats left before the next 4 KB page boundary, given the in-page offset.
  function automatic logic [12:0] page_beats(input logic [11:0] off);
    return (13'(BOUNDARY) - {1'b0, off}) / 13'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/ervp_dma_burst_sizer.sv
// Burst length selector: smallest of remaining beats, MAX_BEATS and the
// beats left in the current 4 KB page on the source and destination side.
module ervp_dma_burst_sizer
  import ervp_dma_seq_pkg::*;
#(
  parameter int BW_LEN    = 32,
  parameter int MAX_BEATS = 16,
  parameter int BW_BEATS  = 8
) (
  input  logic [BW_LEN-1:0]   rem_beats,
  input  logic [11:0]         src_off,
  input  logic [11:0]         dst_off,
  output logic [BW_BEATS-1:0] beats
);

  logic [BW_LEN-1:0] src_lim;
  logic [BW_LEN-1:0] dst_lim;
  logic [BW_LEN-1:0] lim;

  always_comb begin
    src_lim = BW_LEN'(page_beats(src_off));
    dst_lim = BW_LEN'(page_beats(dst_off));
    lim     = BW_LEN'(MAX_BEATS);
    if (rem_beats < lim) lim = rem_beats;
    if (src_lim < lim)   lim = src_lim;
    if (dst_lim < lim)   lim = dst_lim;
    beats = BW_BEATS'(lim);
  end

endmodule

// File: rtl/ervp_dma_descriptor_sequencer.sv
// DMA channel control engine: pops descriptors, splits them into page-safe
// read/write bursts and sequences one burst at a time until the FIFOs drain.
module ervp_dma_descriptor_sequencer
  import ervp_dma_seq_pkg::*;
#(
  parameter int BW_ADDR   = 32,
  parameter int BW_LEN    = 32,
  parameter int MAX_BEATS = 16,
  parameter int BW_BEATS  = 8
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                start,
  input  logic                abort,
  input  logic                src_rready,
  input  logic                dst_rready,
  input  logic                len_rready,
  output logic                src_rrequest,
  output logic                dst_rrequest,
  output logic                len_rrequest,
  input  logic [BW_ADDR-1:0]  src_rdata,
  input  logic [BW_ADDR-1:0]  dst_rdata,
  input  logic [BW_LEN-1:0]   len_rdata,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [BW_ADDR-1:0]  rd_addr,
  output logic [BW_BEATS-1:0] rd_beats,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [BW_ADDR-1:0]  wr_addr,
  output logic [BW_BEATS-1:0] wr_beats,
  input  logic                wr_resp,
  output logic [2:0]          status,
  output logic                irq
);

  seq_state_e         state_q, state_d;
  logic [BW_ADDR-1:0] src_q, src_d;
  logic [BW_ADDR-1:0] dst_q, dst_d;
  logic [BW_LEN-1:0]  len_q, len_d;
  logic [BW_LEN-1:0]  rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic               done_q, done_d;
  logic               irq_q, irq_d;
  logic               abort_q, abort_d;
  logic               rd_hold_q, rd_hold_d;
  logic               pop, fin_done, fin_abort, abort_any;
  logic [BW_BEATS-1:0] beats;

  ervp_dma_burst_sizer #(
    .BW_LEN   (BW_LEN),
    .MAX_BEATS(MAX_BEATS),
    .BW_BEATS (BW_BEATS)
  ) u_sizer (
    .rem_beats(rem_q),
    .src_off  (src_q[11:0]),
    .dst_off  (dst_q[11:0]),
    .beats    (beats)
  );

  assign abort_any = abort | abort_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    error_d   = error_q;
    done_d    = done_q;
    irq_d     = 1'b0;
    abort_d   = abort_any;
    rd_hold_d = rd_hold_q;
    pop       = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    fin_done  = 1'b0;
    fin_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start wins over a coincident abort; a stale request never carries over
        abort_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else if (abort) begin
          error_d = 1'b1;
          irq_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (abort_any) begin
          fin_abort = 1'b1;
        end else if (src_rready && dst_rready && len_rready) begin
          pop     = 1'b1;
          src_d   = src_rdata & ~BW_ADDR'(3);
          dst_d   = dst_rdata & ~BW_ADDR'(3);
          len_d   = len_rdata;
          state_d = S_LOAD;
        end else begin
          fin_done = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort_any) begin
          fin_abort = 1'b1;
        end else if (len_q == '0) begin
          state_d = S_FETCH;
        end else if (len_q[1:0] != 2'b00) begin
          error_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          rem_d     = len_q >> 2;
          rd_hold_d = 1'b0;
          state_d   = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        // once the command is on the bus it stays there until accepted
        if (abort_q && !rd_hold_q) begin
          fin_abort = 1'b1;
        end else begin
          rd_valid  = 1'b1;
          rd_hold_d = 1'b1;
          if (rd_ready) begin
            rd_hold_d = 1'b0;
            state_d   = S_WR_CMD;
          end
        end
      end
      S_WR_CMD: begin
        wr_valid = 1'b1;
        if (wr_ready) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (wr_resp) begin
          src_d = src_q + BW_ADDR'(beats) * BW_ADDR'(BEAT_BYTES);
          dst_d = dst_q + BW_ADDR'(beats) * BW_ADDR'(BEAT_BYTES);
          rem_d = rem_q - BW_LEN'(beats);
          if (abort_any)                 fin_abort = 1'b1;
          else if (rem_q == BW_LEN'(beats)) state_d = S_FETCH;
          else                           state_d = S_RD_CMD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin_done) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      irq_d   = 1'b1;
    end
    if (fin_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      error_d = 1'b1;
      irq_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      abort_q   <= 1'b0;
      rd_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      abort_q   <= abort_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  assign src_rrequest = pop;
  assign dst_rrequest = pop;
  assign len_rrequest = pop;
  assign rd_addr      = src_q;
  assign rd_beats     = beats;
  assign wr_addr      = dst_q;
  assign wr_beats     = beats;
  assign irq          = irq_q;

  always_comb begin
    status               = 3'b000;
    status[STATUS_BUSY]  = busy_q;
    status[STATUS_ERROR] = error_q;
    status[STATUS_DONE]  = done_q;
  end

endmodule

// File: tb/tb_ervp_dma_descriptor_sequencer.sv
// Bench for the DMA descriptor sequencer: FIFO and datapath responders with
// random stalls, checked against a burst-list model built from descriptors.
module tb_ervp_dma_descriptor_sequencer;
  localparam int BW_ADDR = 32, BW_LEN = 32, MAX_BEATS = 16, BW_BEATS = 8;

  logic clk = 1'b0, rstnn = 1'b0, start = 1'b0, abort = 1'b0;
  logic src_rready = 1'b0, dst_rready = 1'b0, len_rready = 1'b0;
  logic src_rrequest, dst_rrequest, len_rrequest;
  logic [BW_ADDR-1:0] src_rdata = '0, dst_rdata = '0;
  logic [BW_LEN-1:0]  len_rdata = '0;
  logic rd_valid, rd_ready = 1'b0, wr_valid, wr_ready = 1'b0, wr_resp = 1'b0;
  logic [BW_ADDR-1:0] rd_addr, wr_addr;
  logic [BW_BEATS-1:0] rd_beats, wr_beats;
  logic [2:0] status;
  logic irq;

  always #5 clk = ~clk;

  ervp_dma_descriptor_sequencer #(
    .BW_ADDR(BW_ADDR), .BW_LEN(BW_LEN), .MAX_BEATS(MAX_BEATS), .BW_BEATS(BW_BEATS)
  ) dut (
    .clk(clk), .rstnn(rstnn), .start(start), .abort(abort),
    .src_rready(src_rready), .dst_rready(dst_rready), .len_rready(len_rready),
    .src_rrequest(src_rrequest), .dst_rrequest(dst_rrequest), .len_rrequest(len_rrequest),
    .src_rdata(src_rdata), .dst_rdata(dst_rdata), .len_rdata(len_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_beats(rd_beats),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_beats(wr_beats),
    .wr_resp(wr_resp), .status(status), .irq(irq)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] s; logic [31:0] t; int b; int tag; } burst_t;

  logic [31:0] fq_src[$], fq_dst[$], fq_len[$];
  burst_t exp_b[$];

  task automatic push(input logic [31:0] s, input logic [31:0] t, input logic [31:0] l);
    fq_src.push_back(s); fq_dst.push_back(t); fq_len.push_back(l);
  endtask

  task automatic flush();
    fq_src.delete(); fq_dst.delete(); fq_len.delete();
  endtask

  // Expected burst list from the queued descriptors: page-safe, MAX_BEATS-capped chunks.
  task automatic build_model(output bit err);
    exp_b.delete();
    err = 1'b0;
    for (int i = 0; i < fq_len.size(); i++) begin
      logic [31:0] s, t, l;
      int rem, b, so, dd;
      burst_t e;
      l = fq_len[i];
      if (l == 0) continue;
      if (l % 4 != 0) begin err = 1'b1; continue; end
      rem = int'(l / 4);
      s = fq_src[i] & ~32'd3;
      t = fq_dst[i] & ~32'd3;
      while (rem > 0) begin
        so = int'(s % 32'd4096);
        dd = int'(t % 32'd4096);
        b = (rem < MAX_BEATS) ? rem : MAX_BEATS;
        if ((4096 - so) / 4 < b) b = (4096 - so) / 4;
        if ((4096 - dd) / 4 < b) b = (4096 - dd) / 4;
        e.s = s; e.t = t; e.b = b; e.tag = i;
        exp_b.push_back(e);
        s += 32'(b * 4);
        t += 32'(b * 4);
        rem -= b;
      end
    end
  endtask

  task automatic run(input int abort_at, input int smax, input bit fixed, input bit rst_in_wr);
    bit err, outstanding = 0, aborted = 0, pend_pop = 0, prev_rv = 0, rhp = 0, whp = 0;
    int nexp, pops_exp, nq0, npops = 0, nrd = 0, nwr = 0, nrd_start = 0, nirq = 0;
    int cyc = 0, end_cyc = -1, rdly = 0, rd_cnt = 0, wr_cnt = 0, rd_stall = 0, wr_stall = 0;
    int first_pop = -1, first_rv = -1;
    logic [39:0] rhold, whold;
    build_model(err);
    nq0 = fq_len.size();
    nexp = (abort_at > 0) ? abort_at : exp_b.size();
    pops_exp = (abort_at > 0) ? exp_b[abort_at-1].tag + 1 : nq0;
    forever begin
      @(negedge clk);
      if (pend_pop) begin
        void'(fq_src.pop_front()); void'(fq_dst.pop_front()); void'(fq_len.pop_front());
        pend_pop = 0;
      end
      src_rready = fq_src.size() > 0;
      dst_rready = fq_dst.size() > 0;
      len_rready = fq_len.size() > 0;
      src_rdata  = (fq_src.size() > 0) ? fq_src[0] : '0;
      dst_rdata  = (fq_dst.size() > 0) ? fq_dst[0] : '0;
      len_rdata  = (fq_len.size() > 0) ? fq_len[0] : '0;
      start = (cyc == 0) ? 1'b1 : (status[2] && $urandom_range(0, 15) == 0);
      abort = 1'b0;
      if (abort_at > 0 && !aborted && outstanding && nwr == abort_at) begin
        abort = 1'b1; aborted = 1;
      end
      if (rd_valid) begin
        if (rd_cnt == 0) rd_stall = fixed ? smax : $urandom_range(0, smax);
        rd_ready = (rd_cnt >= rd_stall); rd_cnt++;
      end else begin rd_ready = 1'b0; rd_cnt = 0; end
      if (wr_valid) begin
        if (wr_cnt == 0) wr_stall = fixed ? smax : $urandom_range(0, smax);
        wr_ready = (wr_cnt >= wr_stall); wr_cnt++;
      end else begin wr_ready = 1'b0; wr_cnt = 0; end
      wr_resp = 1'b0;
      if (outstanding) begin
        if (rdly == 0) begin wr_resp = 1'b1; outstanding = 0; end
        else rdly--;
      end else if ($urandom_range(0, 9) == 0) wr_resp = 1'b1;
      #1;
      if (cyc == 1) chk("busy_set", status[2], 1'b1);
      if (src_rrequest) begin
        chk("pop_together", {dst_rrequest, len_rrequest}, 2'b11);
        pend_pop = 1; npops++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (rd_valid && !prev_rv) begin
        nrd_start++;
        if (first_rv < 0) first_rv = cyc;
      end
      prev_rv = rd_valid;
      if (rhp) chk("rd_hold", {rd_valid, rd_addr, rd_beats}, {1'b1, rhold});
      if (whp) chk("wr_hold", {wr_valid, wr_addr, wr_beats}, {1'b1, whold});
      rhp = rd_valid && !rd_ready; rhold = {rd_addr, rd_beats};
      whp = wr_valid && !wr_ready; whold = {wr_addr, wr_beats};
      if (rd_valid && rd_ready) begin
        if (nrd < nexp) begin
          chk("rd_addr", rd_addr, exp_b[nrd].s);
          chk("rd_beats", rd_beats, exp_b[nrd].b);
        end else chk("rd_extra_idx", nrd, nexp - 1);
        nrd++;
      end
      if (wr_valid && wr_ready) begin
        if (nwr < nexp) begin
          chk("wr_addr", wr_addr, exp_b[nwr].t);
          chk("wr_beats", wr_beats, exp_b[nwr].b);
        end else chk("wr_extra_idx", nwr, nexp - 1);
        nwr++;
        outstanding = 1;
        rdly = fixed ? smax : $urandom_range(0, 3);
      end
      if (irq) nirq++;
      if (rst_in_wr && wr_valid) begin
        start = 1'b0; abort = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0; wr_resp = 1'b0;
        rstnn = 1'b0;
        #1;
        chk("rst_outputs", {src_rrequest, dst_rrequest, len_rrequest, rd_valid, wr_valid,
                            rd_addr, rd_beats, irq}, '0);
        chk("rst_wr", {wr_addr, wr_beats}, '0);
        chk("rst_status", status, 3'b000);
        @(negedge clk);
        rstnn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_irq", {irq, status}, 4'b0000);
        end
        return;
      end
      if (end_cyc < 0 && cyc > 0 && !status[2]) end_cyc = cyc;
      if (end_cyc >= 0 && cyc >= end_cyc + 3) break;
      if (cyc > 3000) begin
        chk("timeout_cycles", cyc, 0);
        break;
      end
      cyc++;
    end
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0; wr_resp = 1'b0;
    chk("n_rd_cmds", nrd_start, nexp);
    chk("n_wr_cmds", nwr, nexp);
    chk("n_pops", npops, pops_exp);
    chk("fifo_left", fq_len.size(), nq0 - pops_exp);
    chk("irq_cycles", nirq, 1);
    chk("status", status, (abort_at > 0) ? 3'b010 : {1'b0, err, 1'b1});
    if (nq0 > 0) chk("lat_start_pop", first_pop, 1);
    if (exp_b.size() > 0 && exp_b[0].tag == 0) chk("lat_pop_rd", first_rv, 3);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & ~32'd3;
    if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 40));
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0;
    return a;
  endfunction

  function automatic logic [31:0] rand_len();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'd0;
    if (k == 1) return 32'(4 * $urandom_range(1, 20) + $urandom_range(1, 3));
    return 32'(4 * $urandom_range(1, 80));
  endfunction

  initial begin
    bit e;
    int nd, ab;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_status", status, 3'b000);
    chk("reset_outputs", {src_rrequest, dst_rrequest, len_rrequest, rd_valid, wr_valid, irq}, '0);
    chk("reset_cmd", {rd_addr, rd_beats, wr_addr, wr_beats}, '0);
    @(negedge clk);
    rstnn = 1'b1;

    push(32'h1000, 32'h2000, 32'd64);
    run(0, 2, 0, 0);
    push(32'h1000, 32'h2000, 32'd100);
    run(0, 2, 0, 0);
    push(32'h0FF8, 32'h3000, 32'd32);
    run(0, 1, 0, 0);
    push(32'h0100, 32'h8000, 32'd32);
    push(32'h0200, 32'h9000, 32'd6);
    push(32'h0300, 32'hA000, 32'd48);
    run(0, 2, 0, 0);
    push(32'h4000, 32'h5000, 32'd256);
    push(32'h6000, 32'h7000, 32'd16);
    run(1, 3, 1, 0);
    flush();
    push(32'h1000, 32'h2000, 32'd64);
    push(32'h3000, 32'h4000, 32'd32);
    run(0, 0, 0, 1);
    run(0, 1, 0, 0);
    flush();

    repeat (25) begin
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) push(rand_addr(), rand_addr(), rand_len());
      build_model(e);
      ab = (exp_b.size() > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, exp_b.size()) : 0;
      run(ab, 3, 0, 0);
      flush();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
